ntt_mdc_frame_ctrl: RTL

- Frame-level streaming controller that sits in front of and behind an LOGN-stage MDC NTT/INTT pipeline core.
- Generalises the fixed two-lane start/finish interface to LANES parallel lanes with a valid/ready input, per-frame NTT/INTT mode selection and in-flight frame tracking.
- Delays a mode change until the shared-mode pipeline has drained.
- Produces a framed output stream: valid, last, mode tag.

---
 rtl/ntt_mdc_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ntt_mdc_frame_ctrl.sv
// ntt_mdc_frame_ctrl
// Frame-level streaming controller wrapped around an LOGN-stage MDC NTT/INTT
// pipeline core. Accepts LANES coefficients per beat on a valid/ready input,
// tags each frame with its NTT/INTT mode, keeps the shared core mode stable
// while frames are in flight (draining before a mode change), and re-frames
// the core output as a valid/last/mode-tagged stream.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   s_valid/s_ready   input beat handshake
//   s_intt            frame mode (1 = INTT), sampled on the first beat only
//   s_data            LANES*LOGQ input beat, lane k at [k*LOGQ +: LOGQ]
//   core_start        one-cycle pulse with the first beat driven to the core
//   core_intt         mode presented to every core stage
//   core_din          beat driven to the core
//   core_finish       core pulse coincident with its first output beat
//   core_dout         core output beat
//   m_valid/m_last    output framing (no backpressure)
//   m_intt            mode tag of the current output frame
//   m_data            output beat (core_dout delayed one cycle)
//   inflight          frames currently inside the core
//   err               sticky: [0] underrun, [1] finish overlap, [2] spurious finish
module ntt_mdc_frame_ctrl #(
  parameter int LOGQ         = 64,
  parameter int LOGN         = 12,
  parameter int LANES        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_intt,
  input  logic [LANES*LOGQ-1:0]  s_data,
  output logic                   core_start,
  output logic                   core_intt,
  output logic [LANES*LOGQ-1:0]  core_din,
  input  logic                   core_finish,
  input  logic [LANES*LOGQ-1:0]  core_dout,
  output logic                   m_valid,
  output logic                   m_last,
  output logic                   m_intt,
  output logic [LANES*LOGQ-1:0]  m_data,
  output logic [3:0]             inflight,
  output logic [2:0]             err
);

  localparam int W     = LANES * LOGQ;
  localparam int BEATS = (1 << LOGN) / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [3:0]    MAX_IF    = 4'(MAX_INFLIGHT);
  localparam logic [PW-1:0] FIFO_LAST = PW'(MAX_INFLIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic                 run_r;
  logic [CW-1:0]        icnt_r;
  logic [CW-1:0]        ocnt_r;
  logic                 ready_s, start_s, feed_s, underrun_s;
  logic                 core_start_r, core_intt_r;
  logic [W-1:0]         core_din_r;
  logic                 m_valid_r, m_last_r, m_intt_r;
  logic [W-1:0]         m_data_r;
  logic [3:0]           inflight_r;
  logic [2:0]           err_r;
  logic [(1<<PW)-1:0]   fifo_mem_r;
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [3:0]           fifo_cnt_r;
  logic                 start_out_s, abandon_s, dec_s;

  // Input FSM next state, handshake and feed decisions.
  always_comb begin
    state_s    = state_r;
    ready_s    = 1'b0;
    start_s    = 1'b0;
    feed_s     = 1'b0;
    underrun_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A frame of a different mode may only start once the core is empty.
        ready_s = run_r && (inflight_r < MAX_IF) &&
                  ((inflight_r == 4'd0) || (s_intt == core_intt_r));
        if (s_valid && ready_s) begin
          start_s = 1'b1;
          feed_s  = 1'b1;
          state_s = (BEATS == 1) ? IDLE : LOAD;
        end else if (s_valid && (inflight_r != 4'd0) && (s_intt != core_intt_r)) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // The core expects a beat every cycle; a missing beat is zero-filled.
        ready_s    = 1'b1;
        feed_s     = 1'b1;
        underrun_s = !s_valid;
        if (icnt_r == LAST_BEAT) begin
          state_s = IDLE;
        end else begin
          state_s = LOAD;
        end
      end
      DRAIN: begin
        if (inflight_r == 4'd0) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output-side event decode: frame start, overlap abandonment, completion.
  always_comb begin
    start_out_s = core_finish && (fifo_cnt_r != 4'd0);
    abandon_s   = core_finish && m_valid_r && !m_last_r;
    dec_s       = (m_valid_r && m_last_r) || abandon_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Holds s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Core-side input registers and input beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_start_r <= 1'b0;
      core_intt_r  <= 1'b0;
      core_din_r   <= {W{1'b0}};
      icnt_r       <= {CW{1'b0}};
    end else begin
      core_start_r <= start_s;
      core_din_r   <= (feed_s && s_valid) ? s_data : {W{1'b0}};
      if (start_s) begin
        core_intt_r <= s_intt;
        icnt_r      <= (BEATS == 1) ? {CW{1'b0}} : CW'(1);
      end else if (state_r == LOAD) begin
        icnt_r <= icnt_r + CW'(1);
      end else begin
        icnt_r <= icnt_r;
      end
    end
  end

  // Output framing: m_data is core_dout delayed once; ocnt tracks the beat on m_*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_intt_r  <= 1'b0;
      m_data_r  <= {W{1'b0}};
      ocnt_r    <= {CW{1'b0}};
    end else begin
      m_data_r <= core_dout;
      if (start_out_s) begin
        m_valid_r <= 1'b1;
        m_last_r  <= (BEATS == 1);
        m_intt_r  <= fifo_mem_r[rd_ptr_r];
        ocnt_r    <= {CW{1'b0}};
      end else if (abandon_s) begin
        // Overlapping finish with no further tag queued: just drop the frame.
        m_valid_r <= 1'b0;
        m_last_r  <= 1'b0;
      end else if (m_valid_r && !m_last_r) begin
        m_valid_r <= 1'b1;
        m_last_r  <= ((ocnt_r + CW'(1)) == LAST_BEAT);
        ocnt_r    <= ocnt_r + CW'(1);
      end else begin
        m_valid_r <= 1'b0;
        m_last_r  <= 1'b0;
      end
    end
  end

  // In-flight frame count: up on acceptance, down on completion or abandonment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= 4'd0;
    end else begin
      case ({start_s, dec_s && (inflight_r != 4'd0)})
        2'b10:   inflight_r <= inflight_r + 4'd1;
        2'b01:   inflight_r <= inflight_r - 4'd1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Mode-tag FIFO, depth MAX_INFLIGHT, circular buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem_r <= {(1<<PW){1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= 4'd0;
    end else begin
      if (start_s) begin
        fifo_mem_r[wr_ptr_r] <= s_intt;
        wr_ptr_r <= (wr_ptr_r == FIFO_LAST) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (start_out_s) begin
        rd_ptr_r <= (rd_ptr_r == FIFO_LAST) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({start_s, start_out_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 4'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 4'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 3'b000;
    end else begin
      err_r <= err_r | {core_finish && (inflight_r == 4'd0), abandon_s, underrun_s};
    end
  end

  assign s_ready    = ready_s;
  assign core_start = core_start_r;
  assign core_intt  = core_intt_r;
  assign core_din   = core_din_r;
  assign m_valid    = m_valid_r;
  assign m_last     = m_last_r;
  assign m_intt     = m_intt_r;
  assign m_data     = m_data_r;
  assign inflight   = inflight_r;
  assign err        = err_r;

endmodule
